// File: rtl/stopwatch_display.sv
// Four-digit multiplexed 7-segment driver for an M.SS.t stopwatch with lap hold.
// Outputs are registered: one cycle after the slot state, count and source digit they show.
module stopwatch_display #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic       lap,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int              CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   LAST      = CW'(REFRESH_DIV - 1);
    localparam logic [CW:0]     BLANK_LIM = (CW + 1)'(BLANK_CYCLES);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;
    typedef enum logic {LIVE, HOLD} mode_t;

    logic [CW-1:0]   count;
    logic            wrap;
    logic            in_blank;
    state_t          state;
    state_t          state_next;
    mode_t           mode;
    logic            lap_q;
    logic            lap_rise;
    logic [3:0][3:0] hold_dig;
    logic [3:0][3:0] live_dig;
    logic [3:0][3:0] src_dig;
    logic [3:0]      digit;
    logic [6:0]      seg_next;
    logic            dp_next;
    logic [3:0]      an_next;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Refresh counter: one digit slot per REFRESH_DIV cycles.
    assign wrap     = (count == LAST);
    assign in_blank = ({1'b0, count} < BLANK_LIM);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Scan FSM: state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // Scan FSM: next state, advancing on the counter wrap.
    always_comb begin
        state_next = state;
        if (wrap) begin
            case (state)
                S0:      state_next = S1;
                S1:      state_next = S2;
                S2:      state_next = S3;
                default: state_next = S0;
            endcase
        end
    end

    // Lap handling: the toggle fires only on the 0->1 transition of the level input.
    assign lap_rise = lap & ~lap_q;
    assign live_dig = {d3, d2, d1, d0};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lap_q    <= 1'b0;
            mode     <= LIVE;
            hold_dig <= '0;
        end else begin
            lap_q <= lap;
            if (lap_rise) begin
                if (mode == LIVE) begin
                    hold_dig <= live_dig;
                    mode     <= HOLD;
                end else begin
                    mode <= LIVE;
                end
            end
        end
    end

    assign src_dig = (mode == HOLD) ? hold_dig : live_dig;
    assign digit   = src_dig[state];

    // Scan FSM: output decode for the slot currently being shown.
    always_comb begin
        an_next  = 4'b1111;
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        if (!in_blank) begin
            case (state)
                S0:      an_next = 4'b1110;
                S1:      an_next = 4'b1101;
                S2:      an_next = 4'b1011;
                default: an_next = 4'b0111;
            endcase
            dp_next = ~((state == S1) || (state == S3));
            // Leading-zero suppression keeps the anode and decimal point lit.
            if ((state == S3) && blank_lz && (digit == 4'd0)) begin
                seg_next = SEG_OFF;
            end else begin
                seg_next = decode(digit);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed and randomized checks of stopwatch_display against a slot/phase reference model.
module tb_stopwatch_display;

    localparam int DIV = 8;
    localparam int BLK = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] din [4];
    logic       lap;
    logic       blank_lz;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         n;
    bit         m_hold;
    logic [3:0] m_hold_d [4];
    bit         m_lap_prev;

    always #5 clock = ~clock;

    stopwatch_display #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
        .clock    (clock),
        .reset    (reset),
        .d0       (din[0]),
        .d1       (din[1]),
        .d2       (din[2]),
        .d3       (din[3]),
        .lap      (lap),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] tab [10];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (v > 4'd9) return 7'b0111111;
        return tab[v];
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed {an,seg,dp}=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        n          = 0;
        m_hold     = 1'b0;
        m_lap_prev = 1'b0;
        for (int k = 0; k < 4; k++) m_hold_d[k] = 4'd0;
    endtask

    // One clock: predict the registered output from this cycle's slot, then compare after the edge.
    task automatic step();
        logic [3:0]  src [4];
        logic [3:0]  one;
        logic [11:0] e;
        int          cnt;
        int          slot;
        bit          rise;
        cnt  = n % DIV;
        slot = (n / DIV) % 4;
        for (int k = 0; k < 4; k++) src[k] = m_hold ? m_hold_d[k] : din[k];
        if (cnt < BLK) begin
            e = {4'b1111, 7'b1111111, 1'b1};
        end else begin
            one = 4'b0001 << slot;
            e[11:8] = ~one;
            e[7:1]  = (slot == 3 && blank_lz && src[3] == 4'd0) ? 7'b1111111 : seg_of(src[slot]);
            e[0]    = (slot % 2 == 0);
        end
        rise = lap && !m_lap_prev;
        @(posedge clock);
        if (rise) begin
            if (!m_hold) begin
                for (int k = 0; k < 4; k++) m_hold_d[k] = din[k];
                m_hold = 1'b1;
            end else begin
                m_hold = 1'b0;
            end
        end
        m_lap_prev = lap;
        n++;
        #1;
        chk("scan", {an, seg, dp}, e);
    endtask

    // True when the output just sampled is the first lit cycle of slot s.
    function automatic bit first_lit(input int s);
        return ((n - 1) % DIV == BLK) && (((n - 1) / DIV) % 4 == s);
    endfunction

    task automatic set_d(input int a, input int b, input int c, input int d);
        din[0] = 4'(a);
        din[1] = 4'(b);
        din[2] = 4'(c);
        din[3] = 4'(d);
    endtask

    initial begin
        logic [11:0] exp22 [4];
        exp22[0] = {4'b1110, 7'b0110000, 1'b1};
        exp22[1] = {4'b1101, 7'b0100100, 1'b0};
        exp22[2] = {4'b1011, 7'b0010010, 1'b1};
        exp22[3] = {4'b0111, 7'b1111000, 1'b0};

        reset    = 1'b1;
        lap      = 1'b0;
        blank_lz = 1'b0;
        set_d(3, 2, 5, 7);
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("reset_state", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        @(negedge clock);
        reset = 1'b0;

        // Reference scan: digits 3,2,5,7, 2-cycle blanking per 8-cycle slot.
        for (int i = 0; i < 4 * DIV; i++) begin
            step();
            if (i % DIV == BLK - 1) chk("slot_blank", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
            if (i % DIV == BLK) chk("scan_ref", {an, seg, dp}, exp22[i / DIV]);
        end

        // Leading-zero suppression on and off.
        din[3]   = 4'd0;
        blank_lz = 1'b1;
        for (int i = 0; i < 4 * DIV; i++) begin
            step();
            if (first_lit(3)) chk("lz_blank", {an, seg, dp}, {4'b0111, 7'b1111111, 1'b0});
        end
        blank_lz = 1'b0;
        for (int i = 0; i < 4 * DIV; i++) begin
            step();
            if (first_lit(3)) chk("lz_off", {an, seg, dp}, {4'b0111, 7'b1000000, 1'b0});
        end

        // Out-of-range digit shows a dash.
        din[1] = 4'hC;
        for (int i = 0; i < 4 * DIV; i++) begin
            step();
            if (first_lit(1)) chk("dash", {an, seg, dp}, {4'b1101, 7'b0111111, 1'b0});
        end

        // Lap capture of 1234, inputs move to 9999, second lap releases.
        set_d(4, 3, 2, 1);
        lap = 1'b1;
        step();
        lap = 1'b0;
        set_d(9, 9, 9, 9);
        for (int i = 0; i < 5 * DIV; i++) begin
            step();
            if (first_lit(0)) chk("hold_shows_1234", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
        end
        lap = 1'b1;
        step();
        lap = 1'b0;
        for (int i = 0; i < 5 * DIV; i++) begin
            step();
            if (first_lit(0)) chk("live_shows_9999", {an, seg, dp}, {4'b1110, 7'b0010000, 1'b1});
        end

        // Lap held high for 50 cycles: exactly one toggle into HOLD.
        set_d(6, 5, 4, 3);
        lap = 1'b1;
        for (int i = 0; i < 50; i++) step();
        lap = 1'b0;
        set_d(1, 1, 1, 1);
        for (int i = 0; i < 5 * DIV; i++) begin
            step();
            if (first_lit(0)) chk("long_lap_hold", {an, seg, dp}, {4'b1110, 7'b0000010, 1'b1});
        end
        lap = 1'b1;
        step();
        lap = 1'b0;

        // Randomized digits, leading-zero blanking and lap pulses.
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int k = 0; k < 4; k++)
                    din[k] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                         : 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 30) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 20) == 0) lap = ~lap;
            step();
        end
        lap = 1'b0;
        step();

        // Reset in HOLD in the middle of S2.
        set_d(8, 7, 6, 5);
        lap = 1'b1;
        step();
        lap = 1'b0;
        for (int i = 0; i < 8 * DIV; i++) begin
            if ((n % DIV == 4) && ((n / DIV) % 4 == 2)) break;
            step();
        end
        set_d(2, 4, 0, 9);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_async", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        lap = 1'b1;
        @(posedge clock);
        #1;
        chk("reset_over_lap", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        lap = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4 * DIV; i++) begin
            step();
            if (i == BLK) chk("post_reset_S0_live", {an, seg, dp}, {4'b1110, 7'b0100100, 1'b1});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
